sync_fifo_param: RTL and testbench

//   Parametrised single-clock FIFO, successor to the fixed 8-deep FIFO. Adds arbitrary (non-power-of-2)

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_ram.sv | 26 ++
 rtl/sync_fifo_param.sv | 135 +++++++++++++
 tb/tb_sync_fifo_param.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and read-mode encoding for the parametrised FIFO.
package fifo_pkg;

  // Read-port behaviour: registered read or first-word-fall-through.
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Pointer width needed to address 'depth' entries; never below one bit.
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Counter width able to hold every value from 0 up to and including 'depth'.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming word at the write address on an accepted write; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with arbitrary depth, almost-full/almost-empty margins,
// occupancy count, synchronous flush and optional first-word-fall-through read port.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       wr_ack,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       full,
  output logic                       empty,
  output logic                       almostfull,
  output logic                       almostempty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  // Reject configurations whose flags or pointer wrap would be meaningless.
  if (DEPTH < 2 || AF_MARGIN < 1 || AF_MARGIN > DEPTH - 1 ||
      AE_MARGIN < 1 || AE_MARGIN > DEPTH - 1) begin : g_param_check
    $error("sync_fifo_param: DEPTH must be >= 2 and margins within 1..DEPTH-1");
  end

  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wrAck_q, overflow_q, underflow_q;
  logic             flush;
  logic             wrAcc, rdAcc;
  logic [WIDTH-1:0] ramRdata;

  assign flush = rst || clr;
  assign wrAcc = wr_en && !full;
  assign rdAcc = rd_en && !empty;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wrAcc && !flush),
    .waddr (wrPtr_q),
    .wdata (data_in),
    .raddr (rdPtr_q),
    .rdata (ramRdata)
  );

  // Advance pointers with an explicit wrap at DEPTH-1 and track occupancy from the accepted operations.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (wrAcc) begin
      wrPtr_d = (wrPtr_q == PW'(DEPTH - 1)) ? '0 : wrPtr_q + PW'(1);
    end
    if (rdAcc) begin
      rdPtr_d = (rdPtr_q == PW'(DEPTH - 1)) ? '0 : rdPtr_q + PW'(1);
    end
    case ({wrAcc, rdAcc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset and flush both return the FIFO to empty.
  always_ff @(posedge clk) begin
    if (flush) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // One-cycle status pulses reporting the outcome of the previous cycle's requests.
  always_ff @(posedge clk) begin
    if (flush) begin
      wrAck_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrAck_q     <= wr_en && !full;
      overflow_q  <= wr_en && full;
      underflow_q <= rd_en && empty;
    end
  end

  assign wr_ack    = wrAck_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  assign count       = count_q;
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= CW'(DEPTH - AF_MARGIN)) && !full;
  assign almostempty = (count_q <= CW'(AE_MARGIN)) && !empty;

  if (FWFT == int'(FIFO_FWFT)) begin : g_fwft
    // Head of the queue is presented directly; zero while nothing is stored.
    assign data_out = empty ? '0 : ramRdata;
  end else begin : g_std
    logic [WIDTH-1:0] dataOut_q;

    // Registered read: capture the head on an accepted read and hold it otherwise.
    always_ff @(posedge clk) begin
      if (flush) begin
        dataOut_q <= '0;
      end else if (rdAcc) begin
        dataOut_q <= ramRdata;
      end
    end

    assign data_out = dataOut_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench driving a standard-read and a first-word-fall-through FIFO with identical stimulus.
module tb_sync_fifo_param;

  logic        clock = 1'b0;
  logic        rst, clr, wrEn, rdEn;
  logic [15:0] dataIn;

  logic [15:0] dataOutS, dataOutF;
  logic        wrAckS, overflowS, underflowS, fullS, emptyS, afS, aeS;
  logic        wrAckF, overflowF, underflowF, fullF, emptyF, afF, aeF;
  logic [2:0]  countS, countF;

  int          vectors = 0;
  int          miscompares = 0;
  bit          checking = 1'b0;

  logic [15:0] modelQ[$];
  logic [15:0] expStd[$];
  int          modelCount = 0;
  bit          mAck, mOv, mUn, prevRdOk, wa, ra;

  always #5 clock = ~clock;

  sync_fifo_param #(.WIDTH(16), .DEPTH(6), .AF_MARGIN(2), .AE_MARGIN(1), .FWFT(0)) dutStd (
    .clk(clock), .rst(rst), .clr(clr), .wr_en(wrEn), .data_in(dataIn), .rd_en(rdEn),
    .data_out(dataOutS), .wr_ack(wrAckS), .overflow(overflowS), .underflow(underflowS),
    .full(fullS), .empty(emptyS), .almostfull(afS), .almostempty(aeS), .count(countS)
  );

  sync_fifo_param #(.WIDTH(16), .DEPTH(6), .AF_MARGIN(2), .AE_MARGIN(1), .FWFT(1)) dutFwft (
    .clk(clock), .rst(rst), .clr(clr), .wr_en(wrEn), .data_in(dataIn), .rd_en(rdEn),
    .data_out(dataOutF), .wr_ack(wrAckF), .overflow(overflowF), .underflow(underflowF),
    .full(fullF), .empty(emptyF), .almostfull(afF), .almostempty(aeF), .count(countF)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkFlags(input string tag, input logic [2:0] c, input logic f, input logic e,
                            input logic af, input logic ae, input logic ack, input logic ov,
                            input logic un);
    checkOutput({tag, "_count"}, {29'd0, c}, modelCount);
    checkOutput({tag, "_full"}, {31'd0, f}, {31'd0, modelCount == 6});
    checkOutput({tag, "_empty"}, {31'd0, e}, {31'd0, modelCount == 0});
    checkOutput({tag, "_almostfull"}, {31'd0, af}, {31'd0, modelCount >= 4 && modelCount < 6});
    checkOutput({tag, "_almostempty"}, {31'd0, ae}, {31'd0, modelCount == 1});
    checkOutput({tag, "_wr_ack"}, {31'd0, ack}, {31'd0, mAck});
    checkOutput({tag, "_overflow"}, {31'd0, ov}, {31'd0, mOv});
    checkOutput({tag, "_underflow"}, {31'd0, un}, {31'd0, mUn});
  endtask

  task automatic applyStimulus(input logic w, input logic [15:0] d, input logic r,
                               input logic rs, input logic cl);
    @(posedge clock);
    #2;
    wrEn   = w;
    dataIn = d;
    rdEn   = r;
    rst    = rs;
    clr    = cl;
  endtask

  // Reference queue: writes push expected words, accepted reads move the head to the std-port queue.
  always @(posedge clock) begin
    if (rst || clr) begin
      modelCount = 0;
      modelQ.delete();
      mAck = 0; mOv = 0; mUn = 0; prevRdOk = 0;
    end else begin
      wa   = wrEn && modelCount < 6;
      ra   = rdEn && modelCount > 0;
      mAck = wa;
      mOv  = wrEn && modelCount == 6;
      mUn  = rdEn && modelCount == 0;
      if (ra) expStd.push_back(modelQ.pop_front());
      if (wa) modelQ.push_back(dataIn);
      modelCount = modelCount + int'(wa) - int'(ra);
      prevRdOk = rdEn;
    end
  end

  // Monitor: compare flags every cycle and pop the scoreboard whenever a DUT presents read data.
  always @(negedge clock) begin
    if (checking) begin
      checkFlags("std", countS, fullS, emptyS, afS, aeS, wrAckS, overflowS, underflowS);
      checkFlags("fwft", countF, fullF, emptyF, afF, aeF, wrAckF, overflowF, underflowF);
      if (prevRdOk && !underflowS) begin
        if (expStd.size() == 0) checkOutput("std_unexpected_read", {16'd0, dataOutS}, 32'hFFFF_FFFF);
        else checkOutput("std_data", {16'd0, dataOutS}, {16'd0, expStd.pop_front()});
      end
      if (emptyF) begin
        checkOutput("fwft_empty_data", {16'd0, dataOutF}, 32'd0);
      end else if (rdEn) begin
        if (modelQ.size() == 0) checkOutput("fwft_unexpected_head", {16'd0, dataOutF}, 32'hFFFF_FFFF);
        else checkOutput("fwft_head", {16'd0, dataOutF}, {16'd0, modelQ[0]});
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; wrEn = 1'b1; rdEn = 1'b0; dataIn = 16'h1234;
    @(posedge clock);
    @(posedge clock);
    #2;
    rst = 1'b0; wrEn = 1'b0;
    checking = 1'b1;

    $display("[TB] reset");
    @(negedge clock);
    checkOutput("rst_count", {29'd0, countS}, 32'd0);
    checkOutput("rst_empty", {31'd0, emptyS}, 32'd1);
    checkOutput("rst_wr_ack", {31'd0, wrAckS}, 32'd0);
    checkOutput("rst_data_std", {16'd0, dataOutS}, 32'd0);
    checkOutput("rst_data_fwft", {16'd0, dataOutF}, 32'd0);

    $display("[TB] fill");
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("fill_count", {29'd0, countS}, 32'd6);
    checkOutput("fill_full", {31'd0, fullF}, 32'd1);
    checkOutput("fill_overflow", {31'd0, overflowS}, 32'd1);

    $display("[TB] drain");
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("drain_empty", {31'd0, emptyS}, 32'd1);
    checkOutput("drain_last_std", {16'd0, dataOutS}, 32'hA005);
    checkOutput("drain_underflow", {31'd0, underflowF}, 32'd1);

    $display("[TB] wrap");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'hB000 + 16'(r * 16 + i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("wrap_count", {29'd0, countF}, 32'd0);
    checkOutput("wrap_last_std", {16'd0, dataOutS}, 32'hB023);

    $display("[TB] simultaneous");
    applyStimulus(1'b1, 16'hC001, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("sim_empty_count", {29'd0, countS}, 32'd1);
    checkOutput("sim_empty_underflow", {31'd0, underflowS}, 32'd1);
    for (int i = 2; i < 7; i++) applyStimulus(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hC007, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("sim_full_count", {29'd0, countF}, 32'd5);
    checkOutput("sim_full_overflow", {31'd0, overflowF}, 32'd1);
    checkOutput("sim_full_data_std", {16'd0, dataOutS}, 32'hC001);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hC008, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("sim_mid_count", {29'd0, countS}, 32'd3);
    checkOutput("sim_mid_wr_ack", {31'd0, wrAckS}, 32'd1);
    checkOutput("sim_mid_data_std", {16'd0, dataOutS}, 32'hC004);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("sim_tail_data_std", {16'd0, dataOutS}, 32'hC008);

    $display("[TB] flush");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("flush_count", {29'd0, countS}, 32'd0);
    checkOutput("flush_empty", {31'd0, emptyF}, 32'd1);
    checkOutput("flush_no_ack", {31'd0, wrAckS}, 32'd0);
    applyStimulus(1'b1, 16'hC0DE, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("flush_fwft_head", {16'd0, dataOutF}, 32'hC0DE);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("flush_std_data", {16'd0, dataOutS}, 32'hC0DE);
    checkOutput("flush_final_empty", {31'd0, emptyS}, 32'd1);

    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("std_pending_reads", expStd.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
